// File: rtl/cbus_burst_arbiter.sv
// rtl/cbus_burst_arbiter.sv - round-robin burst arbiter sharing one memory-side cbus between requesters
package cbus_pkg;
  // Burst length codes: the value is the beat count minus one.
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  len;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_burst_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_PORTS],
  output cbus_resp_t       iresps [NUM_PORTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx,
  output logic             proto_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last_grant;
  logic [4:0]       beat_cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign busy      = (state == S_BUSY);
  assign grant_idx = sel;

  // Round-robin pick: first valid port after the last one served, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!pick_found && ireqs[(int'(last_grant) + k) % NUM_PORTS].valid) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
      end
    end
  end

  // Pass-through muxing: only the granted port sees the bus while a burst is in progress.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
    end
    if (state == S_BUSY) begin
      oreq        = ireqs[sel];
      iresps[sel] = oresp;
    end
  end

  // Grant FSM, beat counter and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      // A ready beat with nothing outstanding means memory is out of step with us.
      if (oresp.ready && !oreq.valid) begin
        proto_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            sel      <= pick_idx;
            beat_cnt <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!ireqs[sel].valid) begin
            // Requester abandoned the burst; release without flagging an error.
            last_grant <= sel;
            state      <= S_IDLE;
          end else begin
            if (oresp.ready) begin
              beat_cnt <= beat_cnt + 5'd1;
            end
            if (oresp.ready && oresp.last) begin
              // Beats seen including this one must equal len+1.
              if (beat_cnt != {1'b0, ireqs[sel].len}) begin
                proto_err <= 1'b1;
              end
              last_grant <= sel;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
